// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Target end of the core's single-port bus. Each cycle the core presents a
// byte address, and on writes also write data with we=1. This block serves
// word-addressed RAM, a small MMIO page and an error flag for unmapped
// addresses. Read data is registered, so it is valid one cycle after the
// address is presented.
//
// MMIO page (offsets from MMIO_BASE):
//   +0  TXDATA  write pushes data_in[7:0] into the console FIFO; reads 0
//   +4  STATUS  {27'b0, overflow, full, count[2:0]}; any write clears overflow
//   +8  HALT    {23'b0, halt, exit_code}; the first write latches exit_code
//
// Ports:
//   clk        in   1   clock
//   resetn     in   1   asynchronous active-low reset
//   address    in   32  byte address from the core (bits [1:0] ignored)
//   data_in    in   32  write data from the core
//   data_out   out  32  registered read data for the previous address
//   we         in   1   write enable for the current cycle
//   tx_valid   out  1   console FIFO is non-empty
//   tx_data    out  8   byte at the FIFO head
//   tx_ready   in   1   console sink accepts the head byte
//   halt       out  1   program has written the HALT register
//   exit_code  out  8   byte latched by the first HALT write
//   bus_err    out  1   sticky: an unmapped address was accessed
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter string       INIT_FILE  = "",
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BAD_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        we,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [7:0]  exit_code,
    output logic        bus_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // 33 bits so that a 4 GiB RAM limit cannot wrap to zero.
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd4;
    localparam logic [31:0] HALT_ADDR   = MMIO_BASE + 32'd8;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   ram_mem [MEM_WORDS];

    logic [31:0]   data_out_q, data_out_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          halt_q, halt_d;
    logic [7:0]    exit_code_q, exit_code_d;
    logic          bus_err_q, bus_err_d;

    // ------------------------------------------------------------------
    // Address decode. RAM takes priority so that a badly chosen
    // MMIO_BASE cannot hide RAM words.
    // ------------------------------------------------------------------
    logic          is_ram, is_txdata, is_status, is_halt, is_unmapped;
    logic [31:0]   word_addr;
    logic [AW-1:0] ram_index;

    always_comb begin
        word_addr   = {address[31:2], 2'b00};
        ram_index   = address[AW+1:2];
        is_ram      = ({1'b0, address} < RAM_BYTES);
        is_txdata   = !is_ram && (word_addr == TXDATA_ADDR);
        is_status   = !is_ram && (word_addr == STATUS_ADDR);
        is_halt     = !is_ram && (word_addr == HALT_ADDR);
        is_unmapped = !(is_ram || is_txdata || is_status || is_halt);
    end

    // ------------------------------------------------------------------
    // FIFO flags and the saturated count shown in STATUS
    // ------------------------------------------------------------------
    logic        fifo_full;
    logic        pop, push_req, push, drop;
    logic [31:0] count_ext;
    logic [2:0]  status_cnt;

    always_comb begin
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        pop        = (count_q != '0) && tx_ready;
        push_req   = we && is_txdata;
        // A full FIFO still accepts a byte when the head leaves this cycle.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && !push;
        count_ext  = 32'(count_q);
        status_cnt = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    end

    // ------------------------------------------------------------------
    // Read mux. RAM is read combinationally from the array and captured
    // in data_out_q; the array write lands at the same edge, so a read of
    // the word being written returns the old contents (read-first).
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d = BAD_DATA;
        if (is_ram) begin
            data_out_d = ram_mem[ram_index];
        end else if (is_txdata) begin
            data_out_d = 32'd0;
        end else if (is_status) begin
            data_out_d = {27'd0, overflow_q, fifo_full, status_cnt};
        end else if (is_halt) begin
            data_out_d = {23'd0, halt_q, exit_code_q};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the FIFO, the sticky flags and the halt latch
    // ------------------------------------------------------------------
    always_comb begin
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        halt_d      = halt_q;
        exit_code_d = exit_code_q;
        bus_err_d   = bus_err_q || is_unmapped;

        if (push) begin
            fifo_d[wr_ptr_q] = data_in[7:0];
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (we && is_status) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        // HALT is write-once; later writes are ignored until reset.
        if (we && is_halt && !halt_q) begin
            halt_d      = 1'b1;
            exit_code_d = data_in[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers with asynchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out_q  <= '0;
            fifo_q      <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            halt_q      <= 1'b0;
            exit_code_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM array: no reset, so contents survive a reset of the block
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (we && is_ram) begin
            ram_mem[ram_index] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all driven straight from registers
    // ------------------------------------------------------------------
    assign data_out  = data_out_q;
    assign tx_valid  = (count_q != '0);
    assign tx_data   = fifo_q[rd_ptr_q];
    assign halt      = halt_q;
    assign exit_code = exit_code_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Inputs are driven on the falling edge of the clock, and outputs are
// sampled on the next falling edge. Expected read data is queued when an
// address is driven and dequeued once the registered data_out is visible.
// Expected console bytes are queued when a push should be accepted and
// dequeued as the sink takes them.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [31:0] TXA = 32'h8000_0000;
    localparam logic [31:0] STA = 32'h8000_0004;
    localparam logic [31:0] HLA = 32'h8000_0008;
    localparam logic [31:0] BAD = 32'h4000_0000;

    logic        clk;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        we;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  exit_code;
    logic        bus_err;

    int checks;
    int failures;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];

    mem_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .we        (we),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .exit_code (exit_code),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bus cycle, then wait until its registered result is visible.
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        we      = w;
        address = a;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (data_out !== 32'd0) begin failures++; $display("[TB] FAIL rst_data_out got=%h exp=%h", data_out, 32'd0); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'd0) begin failures++; $display("[TB] FAIL rst_tx_data got=%h exp=00", tx_data); end
        checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL rst_halt got=%b exp=0", halt); end
        checks++; if (exit_code !== 8'd0) begin failures++; $display("[TB] FAIL rst_exit_code got=%h exp=00", exit_code); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_bus_err got=%b exp=0", bus_err); end
    endtask

    task automatic test_ram();
        logic [31:0] exp;
        drive(1'b1, 32'h10, 32'h1234_5678);
        rd_q.push_back(32'h1234_5678);
        drive(1'b0, 32'h10, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_read got=%h exp=%h", data_out, exp); end
        // Overwrite the same word: the write cycle must return the old word.
        rd_q.push_back(32'h1234_5678);
        drive(1'b1, 32'h10, 32'hCAFE_F00D);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_read_first got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'hCAFE_F00D);
        drive(1'b0, 32'h10, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_new_word got=%h exp=%h", data_out, exp); end
        // Last word of the RAM.
        drive(1'b1, 32'h3FFC, 32'hA5A5_5A5A);
        rd_q.push_back(32'hA5A5_5A5A);
        drive(1'b0, 32'h3FFC, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_top_word got=%h exp=%h", data_out, exp); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL ram_no_bus_err got=%b exp=0", bus_err); end
    endtask

    task automatic test_fifo();
        logic [31:0] exp;
        logic [7:0]  eb;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'(8'h41 + i));
            rd_q.push_back(32'd0);
            drive(1'b1, TXA, 32'(32'h41 + i));
            exp = rd_q.pop_front();
            checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL txdata_reads_zero got=%h exp=%h", data_out, exp); end
        end
        rd_q.push_back(32'h3);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_count3 got=%h exp=%h", data_out, exp); end
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("[TB] FAIL fifo_valid got=%b exp=1", tx_valid); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eb = tx_q.pop_front();
            checks++; if (tx_valid !== 1'b1 || tx_data !== eb) begin failures++; $display("[TB] FAIL fifo_order valid=%b got=%h exp=%h", tx_valid, tx_data, eb); end
            drive(1'b0, 32'd0, 32'd0);
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL fifo_drained got=%b exp=0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        logic [7:0]  eb;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tx_q.push_back(8'(8'h50 + i));
            drive(1'b1, TXA, 32'(32'h50 + i));
        end
        rd_q.push_back(32'h1C);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_overflow got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'h1C);
        drive(1'b1, STA, 32'hFFFF_FFFF);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_write_cycle got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'h0C);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_cleared got=%h exp=%h", data_out, exp); end
        // Push into a full FIFO while the head leaves in the same cycle.
        tx_ready = 1'b1;
        eb = tx_q.pop_front();
        checks++; if (tx_data !== eb) begin failures++; $display("[TB] FAIL full_head got=%h exp=%h", tx_data, eb); end
        tx_q.push_back(8'h60);
        drive(1'b1, TXA, 32'h60);
        tx_ready = 1'b0;
        rd_q.push_back(32'h0C);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL full_push_pop got=%h exp=%h", data_out, exp); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eb = tx_q.pop_front();
            checks++; if (tx_valid !== 1'b1 || tx_data !== eb) begin failures++; $display("[TB] FAIL ovf_order valid=%b got=%h exp=%h", tx_valid, tx_data, eb); end
            drive(1'b0, 32'd0, 32'd0);
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained got=%b exp=0", tx_valid); end
        rd_q.push_back(32'h0);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_empty got=%h exp=%h", data_out, exp); end
    endtask

    task automatic test_halt();
        logic [31:0] exp;
        checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL halt_idle got=%b exp=0", halt); end
        rd_q.push_back(32'h0);
        drive(1'b1, HLA, 32'h0000_0007);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL halt_rd_before got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'h107);
        drive(1'b1, HLA, 32'h0000_0009);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL halt_second_write got=%h exp=%h", data_out, exp); end
        checks++; if (halt !== 1'b1) begin failures++; $display("[TB] FAIL halt_set got=%b exp=1", halt); end
        checks++; if (exit_code !== 8'h07) begin failures++; $display("[TB] FAIL exit_code got=%h exp=07", exit_code); end
        rd_q.push_back(32'h107);
        drive(1'b0, HLA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL halt_read got=%h exp=%h", data_out, exp); end
    endtask

    task automatic test_bus_err();
        logic [31:0] exp;
        drive(1'b1, 32'h0, 32'h1111_2222);
        checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL bus_err_idle got=%b exp=0", bus_err); end
        rd_q.push_back(32'hDEAD_BEEF);
        drive(1'b0, BAD, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL unmapped_read got=%h exp=%h", data_out, exp); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("[TB] FAIL bus_err_set got=%b exp=1", bus_err); end
        drive(1'b1, BAD, 32'h9999_9999);
        rd_q.push_back(32'h1111_2222);
        drive(1'b0, 32'h0, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_untouched got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'hDEAD_BEEF);
        drive(1'b0, 32'h8000_000C, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL mmio_hole got=%h exp=%h", data_out, exp); end
        drive(1'b0, 32'h0, 32'd0);
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        tx_ready = 1'b0;
        drive(1'b1, TXA, 32'h71);
        drive(1'b1, TXA, 32'h72);
        we      = 1'b0;
        address = 32'h0;
        checks++; if (tx_valid !== 1'b1 || halt !== 1'b1 || bus_err !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset valid=%b halt=%b bus_err=%b exp=111", tx_valid, halt, bus_err); end
        // Assert reset in the low half of the clock, well away from any edge.
        #2 resetn = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (halt !== 1'b0) begin failures++; $display("[TB] FAIL async_halt got=%b exp=0", halt); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL async_bus_err got=%b exp=0", bus_err); end
        checks++; if (exit_code !== 8'd0) begin failures++; $display("[TB] FAIL async_exit_code got=%h exp=00", exit_code); end
        checks++; if (data_out !== 32'd0) begin failures++; $display("[TB] FAIL async_data_out got=%h exp=0", data_out); end
        checks++; if (tx_data !== 8'd0) begin failures++; $display("[TB] FAIL async_tx_data got=%h exp=00", tx_data); end
        @(negedge clk);
        resetn = 1'b1;
        tx_q.delete();
        rd_q.push_back(32'hCAFE_F00D);
        drive(1'b0, 32'h10, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL ram_kept got=%h exp=%h", data_out, exp); end
        rd_q.push_back(32'h0);
        drive(1'b0, STA, 32'd0);
        exp = rd_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("[TB] FAIL status_after_reset got=%h exp=%h", data_out, exp); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        we       = 1'b0;
        address  = 32'h0;
        data_in  = 32'h0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_ram();
        test_fifo();
        test_overflow();
        test_halt();
        test_bus_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
